mem_arbiter: RTL

//  Shares the single RAM port between icache and dcache. Grants one requester at a time.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_flex_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// mem_arbiter_pkg : shared types for the icache/dcache RAM port arbiter
// Revision 1.0
// =============================================================================
package mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   // Encoding doubles as the owner output: 00 none, 01 icache, 10 dcache.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_I = 2'b01,
      GRANT_D = 2'b10
   } arb_state_t;

   localparam int CNT_W    = 4;
   localparam int STARVE_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_flex_counter.sv
`default_nettype none
// =============================================================================
// mem_arbiter_flex_counter : clearable up-counter with programmable rollover
// Revision 1.0
// =============================================================================
module mem_arbiter_flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic [WIDTH-1:0] count_out
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == rollover_val) ? WIDTH'(1) : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_out = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter : shares one RAM port between icache and dcache with burst hold
// Revision 1.0
// =============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int D_BURST      = 2,
   parameter int I_BURST      = 1,
   parameter int STARVE_LIMIT = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [1:0]  owner,
   output logic        ram_err
);

   arb_state_t          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                ram_err_q, ram_err_d;
   logic [CNT_W-1:0]    word_cnt;
   logic [CNT_W-1:0]    burst_len;
   logic                dreq, starved, req_active, complete, release_grant, count_en;

   assign dreq    = dREN | dWEN;
   assign starved = (starve_q >= STARVE_W'(STARVE_LIMIT));

   mem_arbiter_flex_counter #(.WIDTH(CNT_W)) u_word_cnt (
      .clk          (CLK),
      .rst_n        (nRST),
      .clear        (release_grant),
      .count_enable (count_en),
      .rollover_val (burst_len),
      .count_out    (word_cnt)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         ram_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         ram_err_q <= ram_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      ram_err_d     = ram_err_q;
      req_active    = 1'b0;
      burst_len     = CNT_W'(D_BURST);
      complete      = 1'b0;
      release_grant = 1'b0;
      count_en      = 1'b0;

      case (state_q)
         GRANT_I: begin
            req_active = iREN;
            burst_len  = CNT_W'(I_BURST);
         end
         GRANT_D: begin
            req_active = dreq;
            burst_len  = CNT_W'(D_BURST);
         end
         default: ;
      endcase

      if (state_q != IDLE) begin
         complete      = req_active && (ramstate == ACCESS);
         count_en      = complete;
         // A dropped request releases immediately, even without a completion.
         release_grant = !req_active || (complete && ((word_cnt + CNT_W'(1)) == burst_len));
         if (ramstate == ERROR) ram_err_d = 1'b1;
         if (release_grant)     state_d   = IDLE;
      end else begin
         if (dreq && (!iREN || !starved)) state_d = GRANT_D;
         else if (iREN)                   state_d = GRANT_I;
      end

      if (!iREN) begin
         starve_d = '0;
      end else if (state_q == IDLE && state_d == GRANT_I) begin
         starve_d = '0;
      end else if (state_q != GRANT_I && !starved) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (state_q)
         GRANT_I: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iwait   = !complete;
         end
         GRANT_D: begin
            // Write wins when both dcache enables are raised.
            ramWEN   = dWEN;
            ramREN   = dREN && !dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = !complete;
         end
         default: ;
      endcase
   end

   assign iload   = ramload;
   assign dload   = ramload;
   assign owner   = state_q;
   assign ram_err = ram_err_q;

endmodule
`default_nettype wire
